addsub_accum_ctrl: RTL and testbench

ADDSUB_ACCUM_CTRL -- requirements
Module: addsub_accum_ctrl

---
 rtl/addsub_accum_ctrl.sv | 139 +++++++++++++
 tb/tb_addsub_accum_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accum_ctrl.sv
// 4-bit accumulator sequencer that drives an external add_Sub_4bit through an
// IDLE/EXEC/RESP handshake, with optional saturation and a sticky overflow flag.
module addsub_accum_ctrl #(
  parameter bit OVF_SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  output logic       as_op,
  input  logic [3:0] as_sum,
  input  logic       as_cout,
  input  logic       as_v,
  output logic [3:0] acc,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_cout,
  output logic       res_v,
  output logic       sticky_ovf,
  input  logic       ovf_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t     state_r;
  logic [1:0] op_r;
  logic [3:0] opnd_r;
  logic [3:0] arith_next_s;

  // Overflow can only push away from the pre-op sign, so that sign picks the rail.
  function automatic logic [3:0] sat_value(input logic sign);
    return sign ? 4'b1000 : 4'b0111;
  endfunction

  // ADD/SUB result, clamped on signed overflow when saturation is enabled
  always_comb begin
    if (as_v && OVF_SATURATE) begin
      arith_next_s = sat_value(acc[3]);
    end else begin
      arith_next_s = as_sum;
    end
  end

  // adder operand decode; operand and direction only presented during EXEC
  always_comb begin
    as_a = acc;
    if (state_r == EXEC) begin
      as_b  = opnd_r;
      as_op = (op_r == OP_SUB);
    end else begin
      as_b  = 4'b0000;
      as_op = 1'b0;
    end
  end

  // command sequencer, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      opnd_r     <= 4'b0000;
      acc        <= 4'b0000;
      cmd_ready  <= 1'b1;
      res_valid  <= 1'b0;
      res_cout   <= 1'b0;
      res_v      <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      // an overflow or CLEAR in the same cycle overrides this
      if (ovf_clr) begin
        sticky_ovf <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_r      <= cmd_op;
            opnd_r    <= cmd_data;
            cmd_ready <= 1'b0;
            state_r   <= EXEC;
          end
        end
        EXEC: begin
          case (op_r)
            OP_LOAD: begin
              acc      <= opnd_r;
              res_cout <= 1'b0;
              res_v    <= 1'b0;
            end
            OP_ADD, OP_SUB: begin
              acc      <= arith_next_s;
              res_cout <= as_cout;
              res_v    <= as_v;
              if (as_v) begin
                sticky_ovf <= 1'b1;
              end
            end
            OP_CLEAR: begin
              acc        <= 4'b0000;
              res_cout   <= 1'b0;
              res_v      <= 1'b0;
              sticky_ovf <= 1'b0;
            end
            default: begin
              acc <= acc;
            end
          endcase
          res_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Bench for addsub_accum_ctrl: wrapping and saturating instances share stimulus,
// each with its own add_Sub_4bit model, checked against an integer reference.
module tb_addsub_accum_ctrl;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SUB   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, res_ready, ovf_clr;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;

  logic       cmd_ready0, res_valid0, res_cout0, res_v0, sticky0, as_op0, as_cout0, as_v0;
  logic [3:0] as_a0, as_b0, as_sum0, acc0;
  logic       cmd_ready1, res_valid1, res_cout1, res_v1, sticky1, as_op1, as_cout1, as_v1;
  logic [3:0] as_a1, as_b1, as_sum1, acc1;

  int n_checks = 0;
  int n_fail   = 0;
  int macc0, macc1, ms0, ms1;

  always #5 clk = ~clk;

  // add_Sub_4bit: ripple add of a and (b or ~b) with carry-in = op
  function automatic logic [5:0] addsub(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic [3:0] bb;
    logic [4:0] t;
    bb = op ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {4'b0000, op};
    return {(a[3] == bb[3]) && (t[3] != a[3]), t[4], t[3:0]};
  endfunction

  always_comb {as_v0, as_cout0, as_sum0} = addsub(as_a0, as_b0, as_op0);
  always_comb {as_v1, as_cout1, as_sum1} = addsub(as_a1, as_b1, as_op1);

  addsub_accum_ctrl #(.OVF_SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .as_a(as_a0), .as_b(as_b0), .as_op(as_op0),
    .as_sum(as_sum0), .as_cout(as_cout0), .as_v(as_v0), .acc(acc0),
    .res_valid(res_valid0), .res_ready(res_ready), .res_cout(res_cout0), .res_v(res_v0),
    .sticky_ovf(sticky0), .ovf_clr(ovf_clr)
  );

  addsub_accum_ctrl #(.OVF_SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .as_a(as_a1), .as_b(as_b1), .as_op(as_op1),
    .as_sum(as_sum1), .as_cout(as_cout1), .as_v(as_v1), .acc(acc1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_cout(res_cout1), .res_v(res_v1),
    .sticky_ovf(sticky1), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, carry from unsigned sums.
  task automatic model_step(input int a, input logic [1:0] op, input int d, input bit sat,
                            output int na, output int co, output int ov);
    int sa, sd, s;
    sa = (a > 7) ? a - 16 : a;
    sd = (d > 7) ? d - 16 : d;
    na = 0; co = 0; ov = 0;
    case (op)
      LOAD: na = d;
      ADD: begin
        s  = sa + sd;
        co = (a + d > 15) ? 1 : 0;
        ov = (s > 7 || s < -8) ? 1 : 0;
        na = (ov == 1 && sat) ? ((s > 7) ? 7 : 8) : (a + d) % 16;
      end
      SUB: begin
        s  = sa - sd;
        co = (a >= d) ? 1 : 0;
        ov = (s > 7 || s < -8) ? 1 : 0;
        na = (ov == 1 && sat) ? ((s > 7) ? 7 : 8) : (a - d + 16) % 16;
      end
      default: na = 0;
    endcase
  endtask

  task automatic check_state(input string tag, input logic valid, input logic ready);
    check({tag, "_valid0"}, 8'(res_valid0), 8'(valid));
    check({tag, "_valid1"}, 8'(res_valid1), 8'(valid));
    check({tag, "_ready0"}, 8'(cmd_ready0), 8'(ready));
    check({tag, "_ready1"}, 8'(cmd_ready1), 8'(ready));
    check({tag, "_acc0"}, 8'(acc0), 8'(macc0));
    check({tag, "_acc1"}, 8'(acc1), 8'(macc1));
  endtask

  // One command from IDLE back to IDLE; hold = RESP cycles with res_ready low
  // while junk commands are offered.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input bit clr, input int hold);
    int na0, co0, ov0, na1, co1, ov1;
    check("idle_ready0", 8'(cmd_ready0), 8'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; res_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; ovf_clr = clr;
    check_state("exec", 1'b0, 1'b0);
    check("exec_as_a0", 8'(as_a0), 8'(macc0));
    check("exec_as_a1", 8'(as_a1), 8'(macc1));
    check("exec_as_b0", 8'(as_b0), 8'(d));
    check("exec_as_op0", 8'(as_op0), 8'(op == SUB));
    model_step(macc0, op, int'(d), 1'b0, na0, co0, ov0);
    model_step(macc1, op, int'(d), 1'b1, na1, co1, ov1);
    macc0 = na0; macc1 = na1;
    ms0 = (op == CLEAR) ? 0 : (ov0 == 1) ? 1 : clr ? 0 : ms0;
    ms1 = (op == CLEAR) ? 0 : (ov1 == 1) ? 1 : clr ? 0 : ms1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_state("resp", 1'b1, 1'b0);
    check("resp_cout0", 8'(res_cout0), 8'(co0));
    check("resp_cout1", 8'(res_cout1), 8'(co1));
    check("resp_v0", 8'(res_v0), 8'(ov0));
    check("resp_v1", 8'(res_v1), 8'(ov1));
    check("resp_sticky0", 8'(sticky0), 8'(ms0));
    check("resp_sticky1", 8'(sticky1), 8'(ms1));
    check("resp_as_b0", 8'(as_b0), 8'd0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check_state("hold", 1'b1, 1'b0);
      check("hold_cout0", 8'(res_cout0), 8'(co0));
      check("hold_v0", 8'(res_v0), 8'(ov0));
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_state("release", 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; ovf_clr = 1'b0;
    cmd_op = 2'b00; cmd_data = 4'b0000;
    macc0 = 0; macc1 = 0; ms0 = 0; ms1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 1'b0, 1'b1);
    check("reset_sticky0", 8'(sticky0), 8'd0);
    check("reset_cout0", 8'(res_cout0), 8'd0);
    check("reset_v0", 8'(res_v0), 8'd0);
    check("reset_as_b0", 8'(as_b0), 8'd0);
    check("reset_as_op0", 8'(as_op0), 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // signed overflow: wrap vs saturate
    do_cmd(LOAD, 4'd5, 1'b0, 0);
    do_cmd(ADD, 4'd3, 1'b0, 0);
    check("ovf_wrap_acc", 8'(acc0), 8'h08);
    check("ovf_sat_acc", 8'(acc1), 8'h07);
    check("ovf_sticky", 8'(sticky0), 8'd1);

    // subtraction carry = no-borrow
    do_cmd(LOAD, 4'd3, 1'b0, 0);
    do_cmd(SUB, 4'd5, 1'b0, 0);
    check("sub_neg_acc", 8'(acc0), 8'h0e);
    do_cmd(LOAD, 4'd7, 1'b0, 0);
    do_cmd(SUB, 4'd2, 1'b0, 0);
    check("sub_pos_acc", 8'(acc0), 8'h05);

    // back-pressure in RESP with commands offered
    do_cmd(LOAD, 4'd1, 1'b0, 0);
    do_cmd(ADD, 4'd2, 1'b0, 3);

    // set beats simultaneous clear; later clear and CLEAR command
    do_cmd(LOAD, 4'd4, 1'b0, 0);
    do_cmd(ADD, 4'd4, 1'b1, 0);
    check("ovf_clr_collide", 8'(sticky0), 8'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0; ms0 = 0; ms1 = 0;
    check("ovf_clr0", 8'(sticky0), 8'd0);
    check("ovf_clr1", 8'(sticky1), 8'd0);
    do_cmd(LOAD, 4'd7, 1'b0, 0);
    do_cmd(ADD, 4'd1, 1'b0, 0);
    do_cmd(CLEAR, 4'd9, 1'b0, 0);
    check("clear_acc", 8'(acc0), 8'd0);
    check("clear_sticky", 8'(sticky1), 8'd0);

    // reset asserted during EXEC aborts the ADD
    do_cmd(LOAD, 4'd6, 1'b0, 0);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 4'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    macc0 = 0; macc1 = 0; ms0 = 0; ms1 = 0;
    check_state("async_rst", 1'b0, 1'b1);
    check("async_rst_as_b", 8'(as_b0), 8'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("post_rst", 1'b0, 1'b1);
    do_cmd(LOAD, 4'd2, 1'b0, 0);
    check("post_rst_load", 8'(acc0), 8'h02);

    // random command mix
    for (int k = 0; k < 40; k++) begin
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
